// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends start/8 data/odd parity/stop,
// checks the device acknowledge and reports done or error in the system clock domain.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5760,
    parameter int unsigned REQ_CYCLES     = 96,
    parameter int unsigned TIMEOUT_CYCLES = 768000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FILT_W    = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_START,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    logic [1:0]        clk_meta;
    logic [1:0]        data_meta;
    logic [FILT_W-1:0] clk_flt_cnt;
    logic [FILT_W-1:0] data_flt_cnt;
    logic              clk_filt;
    logic              clk_filt_d;
    logic              data_filt;
    logic              fall;

    state_t             state;
    logic [PHASE_W-1:0] phase_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [3:0]         bit_cnt;
    logic [7:0]         data_q;
    logic               parity_q;
    logic               waiting;
    logic               expired;

    // Synchronize and debounce the clock line; a level change needs FILTER_LEN equal samples
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta    <= 2'b11;
            clk_flt_cnt <= '0;
            clk_filt    <= 1'b1;
            clk_filt_d  <= 1'b1;
        end else begin
            clk_meta   <= {clk_meta[0], ps2_clk_in};
            clk_filt_d <= clk_filt;
            if (clk_meta[1] == clk_filt) begin
                clk_flt_cnt <= '0;
            end else if (clk_flt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                clk_filt    <= clk_meta[1];
                clk_flt_cnt <= '0;
            end else begin
                clk_flt_cnt <= clk_flt_cnt + FILT_W'(1);
            end
        end
    end

    // Same conditioning for the data line
    always_ff @(posedge clk) begin
        if (reset) begin
            data_meta    <= 2'b11;
            data_flt_cnt <= '0;
            data_filt    <= 1'b1;
        end else begin
            data_meta <= {data_meta[0], ps2_data_in};
            if (data_meta[1] == data_filt) begin
                data_flt_cnt <= '0;
            end else if (data_flt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                data_filt    <= data_meta[1];
                data_flt_cnt <= '0;
            end else begin
                data_flt_cnt <= data_flt_cnt + FILT_W'(1);
            end
        end
    end

    assign fall    = clk_filt_d & ~clk_filt;
    assign waiting = (state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT_IDLE);
    // Counter would reach TIMEOUT_CYCLES on this cycle without a device edge
    assign expired = waiting && !fall && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            tx_ready    <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            phase_cnt   <= '0;
            to_cnt      <= '0;
            bit_cnt     <= '0;
            data_q      <= '0;
            parity_q    <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (waiting) begin
                to_cnt <= fall ? '0 : to_cnt + TO_W'(1);
            end

            if (expired) begin
                state       <= S_IDLE;
                tx_ready    <= 1'b1;
                error       <= 1'b1;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                to_cnt      <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (tx_valid) begin
                            data_q     <= tx_data;
                            parity_q   <= ~^tx_data;
                            ps2_clk_oe <= 1'b1;
                            tx_ready   <= 1'b0;
                            phase_cnt  <= '0;
                            state      <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (phase_cnt == PHASE_W'(INHIBIT_CYCLES - 1)) begin
                            phase_cnt   <= '0;
                            ps2_data_oe <= 1'b1;
                            state       <= S_REQ;
                        end else begin
                            phase_cnt <= phase_cnt + PHASE_W'(1);
                        end
                    end
                    S_REQ: begin
                        if (phase_cnt == PHASE_W'(REQ_CYCLES - 1)) begin
                            phase_cnt  <= '0;
                            ps2_clk_oe <= 1'b0;
                            state      <= S_START;
                        end else begin
                            phase_cnt <= phase_cnt + PHASE_W'(1);
                        end
                    end
                    S_START: begin
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                        state   <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        // bit_cnt holds the number of device falling edges seen so far
                        if (fall) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt < 4'd8) begin
                                ps2_data_oe <= ~data_q[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                ps2_data_oe <= ~parity_q;
                            end else begin
                                ps2_data_oe <= 1'b0;
                                state       <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        if (fall) begin
                            if (!data_filt) begin
                                state <= S_WAIT_IDLE;
                            end else begin
                                error    <= 1'b1;
                                tx_ready <= 1'b1;
                                state    <= S_IDLE;
                            end
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (clk_filt && data_filt) begin
                            done     <= 1'b1;
                            tx_ready <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                    default: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b1;
                        state       <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
